// File: rtl/treeval_loader_if.sv
// Node-record handshake between the host and treeval_loader.
// The host drives one record per valid/ready transfer.
interface treeval_loader_if #(
   parameter int unsigned W_ADDR   = 10,
   parameter int unsigned W_ACTION = 3,
   parameter int unsigned W_REWARD = 12,
   parameter int unsigned W_WEIGHT = 7
);
   logic                node_valid;
   logic                node_ready;
   logic [W_ADDR-1:0]   node_parent;
   logic [W_ACTION-1:0] node_action;
   logic [W_REWARD-1:0] node_reward;
   logic [W_WEIGHT-1:0] node_weight;

   modport master (
      output node_valid, node_parent, node_action, node_reward, node_weight,
      input  node_ready
   );

   modport slave (
      input  node_valid, node_parent, node_action, node_reward, node_weight,
      output node_ready
   );
endinterface

// File: rtl/treeval_loader.sv
// Loads a decision tree into treeval through its sideband write strobes,
// releases it, waits for settled passes and returns the root result.
module treeval_loader #(
   parameter int unsigned W_ADDR         = 10,
   parameter int unsigned W_ACTION       = 3,
   parameter int unsigned W_REWARD       = 12,
   parameter int unsigned W_WEIGHT       = 7,
   parameter int unsigned MAX_DATA_WIDTH = 12,
   parameter int unsigned SETTLE_PASSES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 8192
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [W_ADDR-1:0]         cfg_nodes,
   output logic                      busy,
   treeval_loader_if.slave           node,
   output logic                      tv_rst,
   output logic                      tv_mem_par,
   output logic                      tv_mem_act,
   output logic                      tv_mem_rew,
   output logic                      tv_mem_weight,
   output logic [W_ADDR-1:0]         tv_mem_addr,
   output logic [MAX_DATA_WIDTH-1:0] tv_mem_data,
   output logic                      tv_conf_nodes,
   output logic [W_ADDR-1:0]         tv_conf_data,
   input  logic                      tv_exp_change,
   input  logic [W_REWARD-1:0]       tv_exp,
   input  logic [W_ACTION-1:0]       tv_act,
   output logic                      result_valid,
   output logic [W_REWARD-1:0]       result_exp,
   output logic [W_ACTION-1:0]       result_act,
   output logic                      error
);

   localparam int unsigned W_PASS  = (SETTLE_PASSES > 1) ? $clog2(SETTLE_PASSES) : 1;
   localparam int unsigned W_TIMER = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE, S_CONF, S_ACCEPT, S_WR_PAR, S_WR_ACT, S_WR_REW, S_WR_WGT, S_REL, S_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [W_ADDR-1:0]   idx_q, idx_d;
   logic [W_ADDR-1:0]   nodes_q, nodes_d;
   logic [W_ADDR-1:0]   par_q, par_d;
   logic [W_ACTION-1:0] act_q, act_d;
   logic [W_REWARD-1:0] rew_q, rew_d;
   logic [W_WEIGHT-1:0] wgt_q, wgt_d;
   logic                rel_q, rel_d;
   logic [W_PASS-1:0]   pass_q, pass_d;
   logic [W_TIMER-1:0]  timer_q, timer_d;
   logic                prev_q, prev_d;
   logic                node_ready_q;

   logic                      busy_d, node_ready_d, tv_rst_d, conf_d;
   logic                      par_s_d, act_s_d, rew_s_d, wgt_s_d;
   logic [W_ADDR-1:0]         addr_d;
   logic [MAX_DATA_WIDTH-1:0] data_d;
   logic                      res_valid_d, error_d;
   logic [W_REWARD-1:0]       res_exp_d;
   logic [W_ACTION-1:0]       res_act_d;

   assign node.node_ready = node_ready_q;
   assign tv_conf_data    = nodes_q;

   // Next-state logic; registered outputs are decoded from the next state
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      nodes_d     = nodes_q;
      par_d       = par_q;
      act_d       = act_q;
      rew_d       = rew_q;
      wgt_d       = wgt_q;
      rel_d       = rel_q;
      pass_d      = pass_q;
      timer_d     = timer_q;
      prev_d      = prev_q;
      res_exp_d   = result_exp;
      res_act_d   = result_act;
      res_valid_d = 1'b0;
      error_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_nodes >= W_ADDR'(2)) begin
                  nodes_d = cfg_nodes;
                  state_d = S_CONF;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_CONF: begin
            idx_d   = '0;
            state_d = S_ACCEPT;
         end
         S_ACCEPT: begin
            if (node.node_valid && node_ready_q) begin
               // The root has no parent; treeval expects all-ones there
               par_d   = (idx_q == '0) ? '1 : node.node_parent;
               act_d   = node.node_action;
               rew_d   = node.node_reward;
               wgt_d   = node.node_weight;
               state_d = S_WR_PAR;
            end
         end
         S_WR_PAR: state_d = S_WR_ACT;
         S_WR_ACT: state_d = S_WR_REW;
         S_WR_REW: state_d = S_WR_WGT;
         S_WR_WGT: begin
            if (idx_q == nodes_q - W_ADDR'(1)) begin
               rel_d   = 1'b0;
               state_d = S_REL;
            end else begin
               idx_d   = idx_q + W_ADDR'(1);
               state_d = S_ACCEPT;
            end
         end
         S_REL: begin
            if (rel_q) begin
               pass_d  = '0;
               timer_d = '0;
               prev_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               rel_d = 1'b1;
            end
         end
         S_RUN: begin
            prev_d = tv_exp_change;
            if (tv_exp_change && !prev_q) begin
               timer_d = '0;
               if (pass_q == W_PASS'(SETTLE_PASSES - 1)) begin
                  res_exp_d   = tv_exp;
                  res_act_d   = tv_act;
                  res_valid_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  pass_d = pass_q + W_PASS'(1);
               end
            end else if (timer_q == W_TIMER'(TIMEOUT_CYCLES - 1)) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               timer_d = timer_q + W_TIMER'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d       = (state_d != S_IDLE);
      node_ready_d = (state_d == S_ACCEPT);
      tv_rst_d     = (state_d != S_RUN);
      conf_d       = (state_d == S_CONF);
      par_s_d      = 1'b0;
      act_s_d      = 1'b0;
      rew_s_d      = 1'b0;
      wgt_s_d      = 1'b0;
      addr_d       = '0;
      data_d       = '0;
      case (state_d)
         S_WR_PAR: begin par_s_d = 1'b1; addr_d = idx_d; data_d = MAX_DATA_WIDTH'(par_d); end
         S_WR_ACT: begin act_s_d = 1'b1; addr_d = idx_d; data_d = MAX_DATA_WIDTH'(act_d); end
         S_WR_REW: begin rew_s_d = 1'b1; addr_d = idx_d; data_d = MAX_DATA_WIDTH'(rew_d); end
         S_WR_WGT: begin wgt_s_d = 1'b1; addr_d = idx_d; data_d = MAX_DATA_WIDTH'(wgt_d); end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         nodes_q       <= '0;
         par_q         <= '0;
         act_q         <= '0;
         rew_q         <= '0;
         wgt_q         <= '0;
         rel_q         <= 1'b0;
         pass_q        <= '0;
         timer_q       <= '0;
         prev_q        <= 1'b1;
         node_ready_q  <= 1'b0;
         busy          <= 1'b0;
         tv_rst        <= 1'b1;
         tv_conf_nodes <= 1'b0;
         tv_mem_par    <= 1'b0;
         tv_mem_act    <= 1'b0;
         tv_mem_rew    <= 1'b0;
         tv_mem_weight <= 1'b0;
         tv_mem_addr   <= '0;
         tv_mem_data   <= '0;
         result_valid  <= 1'b0;
         result_exp    <= '0;
         result_act    <= '0;
         error         <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         nodes_q       <= nodes_d;
         par_q         <= par_d;
         act_q         <= act_d;
         rew_q         <= rew_d;
         wgt_q         <= wgt_d;
         rel_q         <= rel_d;
         pass_q        <= pass_d;
         timer_q       <= timer_d;
         prev_q        <= prev_d;
         node_ready_q  <= node_ready_d;
         busy          <= busy_d;
         tv_rst        <= tv_rst_d;
         tv_conf_nodes <= conf_d;
         tv_mem_par    <= par_s_d;
         tv_mem_act    <= act_s_d;
         tv_mem_rew    <= rew_s_d;
         tv_mem_weight <= wgt_s_d;
         tv_mem_addr   <= addr_d;
         tv_mem_data   <= data_d;
         result_valid  <= res_valid_d;
         result_exp    <= res_exp_d;
         result_act    <= res_act_d;
         error         <= error_d;
      end
   end

endmodule

// File: tb/tb_treeval_loader.sv
// Directed bench for treeval_loader with a small treeval stub that stores the
// written tree and reports the root's best action and expected reward.
module tb_treeval_loader;

   localparam int unsigned TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  cfg_nodes;
   logic        busy;
   logic        tv_rst, tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight;
   logic [9:0]  tv_mem_addr;
   logic [11:0] tv_mem_data;
   logic        tv_conf_nodes;
   logic [9:0]  tv_conf_data;
   logic        tv_exp_change;
   logic [11:0] tv_exp;
   logic [2:0]  tv_act;
   logic        result_valid;
   logic [11:0] result_exp;
   logic [2:0]  result_act;
   logic        error;

   treeval_loader_if #(.W_ADDR(10), .W_ACTION(3), .W_REWARD(12), .W_WEIGHT(7)) nif ();

   treeval_loader #(
      .W_ADDR(10), .W_ACTION(3), .W_REWARD(12), .W_WEIGHT(7), .MAX_DATA_WIDTH(12),
      .SETTLE_PASSES(2), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_nodes(cfg_nodes), .busy(busy),
      .node(nif.slave),
      .tv_rst(tv_rst), .tv_mem_par(tv_mem_par), .tv_mem_act(tv_mem_act),
      .tv_mem_rew(tv_mem_rew), .tv_mem_weight(tv_mem_weight),
      .tv_mem_addr(tv_mem_addr), .tv_mem_data(tv_mem_data),
      .tv_conf_nodes(tv_conf_nodes), .tv_conf_data(tv_conf_data),
      .tv_exp_change(tv_exp_change), .tv_exp(tv_exp), .tv_act(tv_act),
      .result_valid(result_valid), .result_exp(result_exp), .result_act(result_act),
      .error(error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: records every write and flags illegal strobe combinations
   typedef struct { int kind; int addr; int data; int cyc; } ev_t;
   ev_t trace[$];
   logic log_en    = 1'b0;
   logic multi_bad = 1'b0;
   logic idle_bad  = 1'b0;

   always @(negedge clk) begin
      int nstb;
      nstb = int'(tv_mem_par) + int'(tv_mem_act) + int'(tv_mem_rew) + int'(tv_mem_weight);
      if (nstb > 1) multi_bad <= 1'b1;
      if (nstb == 0 && (tv_mem_addr != '0 || tv_mem_data != '0)) idle_bad <= 1'b1;
      if (log_en) begin
         if (tv_conf_nodes) trace.push_back('{0, 0, int'(tv_conf_data), cyc});
         if (tv_mem_par)    trace.push_back('{1, int'(tv_mem_addr), int'(tv_mem_data), cyc});
         if (tv_mem_act)    trace.push_back('{2, int'(tv_mem_addr), int'(tv_mem_data), cyc});
         if (tv_mem_rew)    trace.push_back('{3, int'(tv_mem_addr), int'(tv_mem_data), cyc});
         if (tv_mem_weight) trace.push_back('{4, int'(tv_mem_addr), int'(tv_mem_data), cyc});
      end
   end

   // Treeval stub: tree memory plus root evaluation (max over actions of weighted child rewards)
   int par_m [8];
   int act_m [8];
   int rew_m [8];
   int wgt_m [8];
   int nodes_m = 0;
   int rc      = 0;
   int stub_mode = 0;

   always @(posedge clk) begin
      rc <= tv_rst ? 0 : rc + 1;
      if (tv_conf_nodes) nodes_m <= int'(tv_conf_data);
      if (tv_mem_addr < 10'd8) begin
         if (tv_mem_par)    par_m[tv_mem_addr[2:0]] <= int'(tv_mem_data);
         if (tv_mem_act)    act_m[tv_mem_addr[2:0]] <= int'(tv_mem_data);
         if (tv_mem_rew)    rew_m[tv_mem_addr[2:0]] <= int'($signed(tv_mem_data));
         if (tv_mem_weight) wgt_m[tv_mem_addr[2:0]] <= int'(tv_mem_data);
      end
   end

   int sum, has, best, bact, found;
   always_comb begin
      sum = 0; has = 0; best = 0; bact = 0; found = 0;
      for (int a = 0; a < 8; a++) begin
         sum = 0;
         has = 0;
         for (int i = 1; i < 8; i++) begin
            if (i < nodes_m && par_m[i] == 0 && act_m[i] == a) begin
               sum = sum + wgt_m[i] * rew_m[i] / 100;
               has = 1;
            end
         end
         if (has != 0 && (found == 0 || sum > best)) begin
            best = sum; bact = a; found = 1;
         end
      end
   end

   assign tv_exp        = 12'(best);
   assign tv_act        = 3'(bact);
   // Mode 1: level high on RUN entry, then 3-cycle pulses rising at run cycles 3, 9, 15...
   assign tv_exp_change = (stub_mode == 1) && (rc < 2 || (rc % 6) >= 3);

   task automatic start_job(input logic [9:0] n);
      @(negedge clk);
      start = 1'b1; cfg_nodes = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_node(input logic [9:0] p, input logic [2:0] a, input logic [11:0] r,
                            input logic [6:0] w);
      logic ok;
      ok = 1'b0;
      nif.node_valid = 1'b1; nif.node_parent = p; nif.node_action = a;
      nif.node_reward = r;   nif.node_weight = w;
      for (int i = 0; i < 200; i++) begin
         if (nif.node_ready) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      nif.node_valid = 1'b0;
      check("handshake", 32'(ok), 32'd1);
   endtask

   task automatic wait_run(output int run_cyc);
      run_cyc = -1;
      for (int i = 0; i < 100; i++) begin
         if (!tv_rst) begin run_cyc = cyc; break; end
         @(negedge clk);
      end
      check("run_entry_reached", 32'(run_cyc >= 0), 32'd1);
   endtask

   function automatic logic [31:0] pack_ev(input int k, input int ad, input int d);
      return {6'd0, 4'(k), 10'(ad), 12'(d)};
   endfunction

   int exp_k [13] = '{0, 1,2,3,4, 1,2,3,4, 1,2,3,4};
   int exp_a [13] = '{0, 0,0,0,0, 1,1,1,1, 2,2,2,2};
   int exp_d [13] = '{3, 12'h3FF,0,0,0, 0,0,40,100, 0,1,80,100};

   initial begin
      int run_cyc, k, stall_bad, rv_seen;
      rst = 1'b1; start = 1'b0; cfg_nodes = '0;
      nif.node_valid = 1'b0; nif.node_parent = '0; nif.node_action = '0;
      nif.node_reward = '0;  nif.node_weight = '0;
      repeat (3) @(negedge clk);

      check("rst_tv_rst",       32'(tv_rst), 32'd1);
      check("rst_busy",         32'(busy), 32'd0);
      check("rst_node_ready",   32'(nif.node_ready), 32'd0);
      check("rst_strobes",      32'({tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight, tv_conf_nodes}), 32'd0);
      check("rst_result_valid", 32'(result_valid), 32'd0);
      check("rst_error",        32'(error), 32'd0);
      check("rst_result",       32'({result_exp, result_act}), 32'd0);
      rst = 1'b0;

      // Illegal node counts
      for (int v = 1; v >= 0; v--) begin
         @(negedge clk);
         start = 1'b1; cfg_nodes = 10'(v);
         @(negedge clk);
         start = 1'b0;
         check("badcfg_error", 32'(error), 32'd1);
         check("badcfg_busy",  32'(busy), 32'd0);
         check("badcfg_conf",  32'(tv_conf_nodes), 32'd0);
         @(negedge clk);
         check("badcfg_error_once", 32'(error), 32'd0);
      end

      // Reset in the middle of loading node 3 of 7
      start_job(10'd7);
      send_node(10'd0, 3'd0, 12'd0, 7'd0);
      send_node(10'd0, 3'd1, 12'd5, 7'd50);
      send_node(10'd0, 3'd2, 12'd7, 7'd50);
      @(negedge clk);
      check("midload_strobe_active", 32'(tv_mem_act), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_tv_rst",  32'(tv_rst), 32'd1);
      check("midrst_strobes", 32'({tv_mem_par, tv_mem_act, tv_mem_rew, tv_mem_weight, tv_conf_nodes}), 32'd0);
      check("midrst_busy",    32'({busy, nif.node_ready, result_valid}), 32'd0);

      // N=3 load and settled run
      stub_mode = 1;
      trace.delete();
      log_en = 1'b1;
      start_job(10'd3);
      send_node(10'd5, 3'd0, 12'd0, 7'd0);
      send_node(10'd0, 3'd0, 12'd40, 7'd100);
      send_node(10'd0, 3'd1, 12'd80, 7'd100);
      wait_run(run_cyc);
      log_en = 1'b0;
      check("load1_trace_len", 32'(trace.size()), 32'd13);
      if (trace.size() == 13) begin
         for (int i = 0; i < 13; i++)
            check($sformatf("load1_ev%0d", i), pack_ev(trace[i].kind, trace[i].addr, trace[i].data),
                  pack_ev(exp_k[i], exp_a[i], exp_d[i]));
         check("load1_cycles", 32'(trace[12].cyc - trace[0].cyc + 1), 32'd16);
         check("rel_to_run",   32'(run_cyc - trace[12].cyc), 32'd3);
      end

      k = 0;
      while (!result_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("result_latency", 32'(k), 32'd10);
      check("result_exp",     32'(result_exp), 32'd80);
      check("result_act",     32'(result_act), 32'd1);
      check("result_tv_rst",  32'(tv_rst), 32'd1);
      @(negedge clk);
      check("result_pulse",   32'({result_valid, busy}), 32'd0);

      // Second load with a stalled handshake, then a silent treeval
      stub_mode = 0;
      trace.delete();
      log_en = 1'b1;
      start_job(10'd3);
      send_node(10'd0, 3'd0, 12'd0, 7'd0);
      send_node(10'd0, 3'd2, 12'hFD8, 7'd50);
      k = 0;
      while (!nif.node_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      stall_bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!nif.node_ready || tv_mem_par || tv_mem_act || tv_mem_rew || tv_mem_weight)
            stall_bad = 1;
         @(negedge clk);
      end
      check("stall_ready_no_strobe", 32'(stall_bad), 32'd0);
      send_node(10'd0, 3'd2, 12'd80, 7'd50);
      wait_run(run_cyc);
      log_en = 1'b0;
      check("load2_trace_len", 32'(trace.size()), 32'd13);
      if (trace.size() == 13) begin
         check("load2_neg_reward", pack_ev(trace[7].kind, trace[7].addr, trace[7].data),
               pack_ev(3, 1, 12'hFD8));
         check("load2_idx_after_stall", pack_ev(trace[9].kind, trace[9].addr, trace[9].data),
               pack_ev(1, 2, 0));
      end

      k = 0;
      rv_seen = 0;
      while (!error && k < 200) begin
         @(negedge clk);
         k++;
         if (result_valid) rv_seen = 1;
      end
      check("timeout_latency",  32'(k), 32'(TIMEOUT));
      check("timeout_no_result", 32'(rv_seen), 32'd0);
      check("timeout_result_kept", 32'({result_exp, result_act}), 32'({12'd80, 3'd1}));
      @(negedge clk);
      check("timeout_idle", 32'({error, busy, tv_rst}), 32'b001);

      check("one_strobe_max",    32'(multi_bad), 32'd0);
      check("idle_addr_data_0",  32'(idle_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
